// File: rtl/hs32_regfile.sv
// hs32 banked register file: two registered read ports, one write port, hardware clear after reset.
// Optional define HS32_REGFILE_BYPASS_EN forwards same-edge write data to a matching read port.
module hs32_regfile #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 4,
  parameter int BANKS      = 2,
  localparam int BANK_W    = (BANKS > 1) ? $clog2(BANKS) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  we,
  input  logic [BANK_W-1:0]     wbank,
  input  logic [ADDR_WIDTH-1:0] wadr,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic [BANK_W-1:0]     rbank,
  input  logic                  rea,
  input  logic                  reb,
  input  logic [ADDR_WIDTH-1:0] radra,
  input  logic [ADDR_WIDTH-1:0] radrb,
  output logic [DATA_WIDTH-1:0] douta,
  output logic [DATA_WIDTH-1:0] doutb,
  output logic                  busy
);

  localparam int DEPTH = BANKS * (2 ** ADDR_WIDTH);
  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = IDX_W + 1;

  typedef enum logic {CLEAR, READY} state_t;

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q;
  logic [DATA_WIDTH-1:0]   mem [DEPTH];

  logic                    wbank_ok, rbank_ok;
  logic [IDX_W-1:0]        widx, ridxa, ridxb;
  logic                    clr_last;
  logic                    wr_en;
  logic [IDX_W-1:0]        wr_idx;
  logic [DATA_WIDTH-1:0]   wr_data;
  logic [DATA_WIDTH-1:0]   next_a, next_b;

  // Bank range checks only exist when BANKS leaves unused bank-select codes.
  generate
    if (BANKS < (1 << BANK_W)) begin : g_bank_chk
      assign wbank_ok = (wbank < BANK_W'(BANKS));
      assign rbank_ok = (rbank < BANK_W'(BANKS));
    end else begin : g_bank_all
      assign wbank_ok = 1'b1;
      assign rbank_ok = 1'b1;
    end
  endgenerate

  assign widx     = IDX_W'({wbank, wadr});
  assign ridxa    = IDX_W'({rbank, radra});
  assign ridxb    = IDX_W'({rbank, radrb});
  assign clr_last = (cnt_q == CNT_W'(DEPTH - 1));
  assign busy     = (state_q == CLEAR);

  // NOTE: every variable assigned in always_comb gets a default first so no latch is inferred.
  always_comb begin
    state_d = state_q;
    case (state_q)
      CLEAR:   if (clr_last) state_d = READY;
      READY:   state_d = READY;
      default: state_d = CLEAR;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= CLEAR;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == CLEAR) cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  // The clear sequencer and the writeback port share the single RAM write port.
  always_comb begin
    wr_en   = 1'b0;
    wr_idx  = widx;
    wr_data = din;
    if (!reset) begin
      if (state_q == CLEAR) begin
        wr_en   = 1'b1;
        wr_idx  = cnt_q[IDX_W-1:0];
        wr_data = '0;
      end else begin
        wr_en   = we && wbank_ok;
      end
    end
  end

  // NOTE: storage has no reset path so it maps onto block RAM; the clear sequencer zeroes it instead.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_idx] <= wr_data;
  end

  always_comb begin
    next_a = '0;
    next_b = '0;
    if (rbank_ok) begin
      next_a = mem[ridxa];
      next_b = mem[ridxb];
`ifdef HS32_REGFILE_BYPASS_EN
      if (we && wbank_ok && ({rbank, radra} == {wbank, wadr})) next_a = din;
      if (we && wbank_ok && ({rbank, radrb} == {wbank, wadr})) next_b = din;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (reset || state_q == CLEAR) begin
      douta <= '0;
      doutb <= '0;
    end else begin
      if (rea) douta <= next_a;
      if (reb) doutb <= next_b;
    end
  end

endmodule

// File: tb/tb_hs32_regfile.sv
// Self-checking bench for hs32_regfile: directed test-plan steps plus a randomized phase
// checked against an array-based reference model; a second instance covers BANKS=3.
module tb_hs32_regfile;

  localparam int DEPTH = 32;
`ifdef HS32_REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        we, rea, reb;
  logic [0:0]  wbank, rbank;
  logic [3:0]  wadr, radra, radrb;
  logic [31:0] din, douta, doutb;
  logic        busy;

  logic        we3, rea3, reb3;
  logic [1:0]  wbank3, rbank3;
  logic [3:0]  wadr3, radra3, radrb3;
  logic [31:0] din3, douta3, doutb3;
  logic        busy3;

  always #5 clk = ~clk;

  hs32_regfile #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .BANKS(2)) dut (
    .clk(clk), .reset(reset), .we(we), .wbank(wbank), .wadr(wadr), .din(din),
    .rbank(rbank), .rea(rea), .reb(reb), .radra(radra), .radrb(radrb),
    .douta(douta), .doutb(doutb), .busy(busy)
  );

  hs32_regfile #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .BANKS(3)) dut3 (
    .clk(clk), .reset(reset), .we(we3), .wbank(wbank3), .wadr(wadr3), .din(din3),
    .rbank(rbank3), .rea(rea3), .reb(reb3), .radra(radra3), .radrb(radrb3),
    .douta(douta3), .doutb(doutb3), .busy(busy3)
  );

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] m_mem [DEPTH];
  int          m_clear_left = 0;
  logic [31:0] m_a = '0, m_b = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock: model predicts from pre-edge inputs, then DUT outputs are compared after the edge.
  task automatic step(input string tag);
    logic [31:0] na, nb;
    int          nclr, ia, ib, iw;
    bit          do_clr, do_w;
    ia = int'(rbank) * 16 + int'(radra);
    ib = int'(rbank) * 16 + int'(radrb);
    iw = int'(wbank) * 16 + int'(wadr);
    do_clr = 1'b0;
    do_w   = 1'b0;
    na = m_a;
    nb = m_b;
    if (reset) begin
      nclr = DEPTH; na = '0; nb = '0; do_clr = 1'b1;
    end else if (m_clear_left > 0) begin
      nclr = m_clear_left - 1; na = '0; nb = '0;
    end else begin
      nclr = 0;
      if (rea) na = (BYP && we && ia == iw) ? din : m_mem[ia];
      if (reb) nb = (BYP && we && ib == iw) ? din : m_mem[ib];
      do_w = we;
    end
    @(posedge clk);
    #1;
    m_clear_left = nclr;
    m_a = na;
    m_b = nb;
    if (do_clr) for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
    if (do_w) m_mem[iw] = din;
    chk({tag, ":busy"}, 32'(busy), 32'(nclr > 0));
    chk({tag, ":douta"}, douta, na);
    chk({tag, ":doutb"}, doutb, nb);
  endtask

  task automatic idle();
    we = 1'b0; rea = 1'b0; reb = 1'b0;
  endtask

  // Steps until busy drops, returning how many cycles it took (bounded).
  task automatic wait_clear(input string tag, output int n);
    n = 0;
    while (busy && n < 100) begin
      step(tag);
      n++;
    end
  endtask

  task automatic wr(input logic b, input logic [3:0] a, input logic [31:0] d, input string tag);
    we = 1'b1; wbank = b; wadr = a; din = d;
    step(tag);
    we = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    reset = 1'b1; we = 1'b0; wbank = '0; wadr = '0; din = '0;
    rbank = '0; rea = 1'b0; reb = 1'b0; radra = '0; radrb = '0;
    we3 = 1'b0; wbank3 = '0; wadr3 = '0; din3 = '0;
    rbank3 = '0; rea3 = 1'b0; reb3 = 1'b0; radra3 = '0; radrb3 = '0;
    for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;

    // Initial reset and clear
    step("rst0");
    step("rst1");
    reset = 1'b0;
    wait_clear("clr0", n);
    chk("clear0_len", n, 32);

    // Preload entry 5, reset, check clear length and that it was wiped
    wr(1'b0, 4'd5, 32'hDEADBEEF, "pre5");
    rea = 1'b1; rbank = 1'b0; radra = 4'd5;
    step("pre5_rd");
    chk("pre5_val", douta, 32'hDEADBEEF);
    idle();
    reset = 1'b1;
    step("rst_pulse");
    reset = 1'b0;
    wait_clear("clr1", n);
    chk("clear1_len", n, 32);
    rea = 1'b1; rbank = 1'b0; radra = 4'd5;
    step("wiped5");
    chk("wiped5_val", douta, 32'h0);
    idle();

    // Dual read and hold
    wr(1'b0, 4'd3, 32'h11111111, "w3");
    wr(1'b0, 4'd7, 32'h22222222, "w7");
    rea = 1'b1; reb = 1'b1; rbank = 1'b0; radra = 4'd3; radrb = 4'd7;
    step("dual");
    chk("dual_a", douta, 32'h11111111);
    chk("dual_b", doutb, 32'h22222222);
    rea = 1'b0; radra = 4'd9;
    step("hold");
    chk("hold_a", douta, 32'h11111111);
    rea = 1'b1; reb = 1'b1; radra = 4'd7; radrb = 4'd7;
    step("same_adr");
    idle();

    // Banking
    wr(1'b1, 4'd3, 32'hCAFEF00D, "w_b1r3");
    rea = 1'b1; reb = 1'b0; rbank = 1'b0; radra = 4'd3;
    step("b0r3");
    chk("b0r3_val", douta, 32'h11111111);
    rbank = 1'b1;
    step("b1r3");
    chk("b1r3_val", douta, 32'hCAFEF00D);
    idle();

    // Read during write
    rbank = 1'b0; radra = 4'd2; rea = 1'b1;
    wr(1'b0, 4'd2, 32'hA5A5A5A5, "rdw");
    chk("rdw_val", douta, BYP ? 32'hA5A5A5A5 : 32'h0);
    rea = 1'b1; radra = 4'd2;
    step("rdw_next");
    chk("rdw_next_val", douta, 32'hA5A5A5A5);
    idle();

    // Write during clear (cycle 10)
    reset = 1'b1;
    step("rst_wdc");
    reset = 1'b0;
    for (int i = 0; i < 9; i++) step("wdc_clr");
    wr(1'b0, 4'd1, 32'h12345678, "wdc_w");
    wait_clear("wdc_rest", n);
    chk("wdc_len", n, 22);
    rea = 1'b1; rbank = 1'b0; radra = 4'd1;
    step("wdc_rd");
    chk("wdc_val", douta, 32'h0);
    idle();

    // Reset mid-clear at cycle 20
    reset = 1'b1;
    step("rst_mc");
    reset = 1'b0;
    for (int i = 0; i < 19; i++) step("mc_clr");
    reset = 1'b1;
    step("mc_rst");
    reset = 1'b0;
    wait_clear("mc_rest", n);
    chk("mc_len", n, 32);

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      we    = 1'($urandom_range(0, 1));
      wbank = 1'($urandom_range(0, 1));
      rbank = 1'($urandom_range(0, 1));
      wadr  = 4'($urandom_range(0, 3));
      radra = 4'($urandom_range(0, 3));
      radrb = 4'($urandom_range(0, 15));
      din   = $urandom;
      rea   = 1'($urandom_range(0, 1));
      reb   = 1'($urandom_range(0, 1));
      step("rand");
    end
    idle();

    // Three-bank instance: out-of-range bank writes are dropped and reads return 0
    chk("b3_busy", 32'(busy3), 32'h0);
    we3 = 1'b1; wbank3 = 2'd3; wadr3 = 4'd3; din3 = 32'hDEADC0DE;
    step("b3_wdrop");
    we3 = 1'b0;
    rea3 = 1'b1; rbank3 = 2'd3; radra3 = 4'd3;
    step("b3_rd3");
    chk("b3_rd3_val", douta3, 32'h0);
    for (int b = 0; b < 3; b++) begin
      rbank3 = 2'(b);
      step("b3_alias");
      chk($sformatf("b3_alias%0d", b), douta3, 32'h0);
    end
    rea3 = 1'b0;
    we3 = 1'b1; wbank3 = 2'd2; wadr3 = 4'd3; din3 = 32'h600DCAFE;
    step("b3_w2");
    we3 = 1'b0;
    rea3 = 1'b1; rbank3 = 2'd2; radra3 = 4'd3;
    step("b3_rd2");
    chk("b3_rd2_val", douta3, 32'h600DCAFE);
    rbank3 = 2'd3;
    step("b3_rd3b");
    chk("b3_rd3b_val", douta3, 32'h0);
    rea3 = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
